// File: rtl/instr_mem_loadable_if.sv
// rtl/instr_mem_loadable_if.sv - fetch and boot-load bus of the loadable instruction memory
//
// Purpose: groups the boot-load byte stream, the PC-side fetch request and
// the decode-side fetch response into one bundle.
// Ports (master = PC/loader side, slave = memory):
//   load_en, load_valid, load_byte -> slave    boot-load stream
//   load_ready                     <- slave    byte accepted this cycle
//   fetch_req, fetch_addr, stall   -> slave    fetch request / downstream stall
//   instr, instr_valid, fault, fault_code, loaded_words <- slave
interface instr_mem_loadable_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048,
   parameter int ADDR_WIDTH = 32
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                  load_en;
   logic                  load_valid;
   logic [7:0]            load_byte;
   logic                  load_ready;
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  stall;
   logic [DATA_WIDTH-1:0] instr;
   logic                  instr_valid;
   logic                  fault;
   logic [1:0]            fault_code;
   logic [LW-1:0]         loaded_words;

   modport master (
      output load_en, load_valid, load_byte, fetch_req, fetch_addr, stall,
      input  load_ready, instr, instr_valid, fault, fault_code, loaded_words
   );

   modport slave (
      input  load_en, load_valid, load_byte, fetch_req, fetch_addr, stall,
      output load_ready, instr, instr_valid, fault, fault_code, loaded_words
   );
endinterface

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - byte-loadable instruction memory with checked synchronous fetch
//
// Purpose: instruction array between the PC register and decode. A byte-serial
// boot-load port fills the array little-endian; fetches return one cycle later
// and are flagged as misaligned (01), out of range (10) or unloaded (11), in
// which case a NOP is returned.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_mem_loadable_if.slave (load stream, fetch request/response)
module instr_mem_loadable #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 2048,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h00000013)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_mem_loadable_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

   state_t                state;
   logic [BCW-1:0]        bcnt;
   logic [DATA_WIDTH-1:0] asm_word;
   logic [DATA_WIDTH-1:0] asm_next;
   // Write pointer and loaded-word count always move together, so one
   // register serves as both.
   logic [LW-1:0]         wptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  load_ready;
   logic                  byte_take;
   logic                  word_done;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  unloaded;

   logic [DATA_WIDTH-1:0] instr_r;
   logic                  valid_r;
   logic                  fault_r;
   logic [1:0]            code_r;

   always_comb begin
      load_ready = (state == LOAD) && (wptr < LW'(DEPTH));
      // A byte presented while load_en is dropping is not taken; the exit
      // transition has priority.
      byte_take  = load_ready && bus.load_en && bus.load_valid;
      word_done  = byte_take && (bcnt == BCW'(BYTES - 1));
      asm_next   = asm_word;
      asm_next[int'(bcnt) * 8 +: 8] = bus.load_byte;
      // Bytes above bcnt are still zero, so FLUSH writes a zero-padded word.
      mem_we     = word_done || (state == FLUSH);
      mem_wdata  = (state == FLUSH) ? asm_word : asm_next;

      idx          = bus.fetch_addr >> OFFW;
      misaligned   = (bus.fetch_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
      out_of_range = idx >= ADDR_WIDTH'(DEPTH);
      unloaded     = idx >= ADDR_WIDTH'(wptr);
   end

   // The array has no reset; wptr < DEPTH whenever mem_we is high.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr[AW-1:0]] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         bcnt     <= '0;
         asm_word <= '0;
         wptr     <= '0;
         instr_r  <= '0;
         valid_r  <= 1'b0;
         fault_r  <= 1'b0;
         code_r   <= 2'b00;
      end else begin
         case (state)
            RUN: begin
               if (bus.load_en) begin
                  // Load wins over a same-cycle fetch.
                  state    <= LOAD;
                  wptr     <= '0;
                  bcnt     <= '0;
                  asm_word <= '0;
                  valid_r  <= 1'b0;
               end else if (!bus.stall) begin
                  valid_r <= bus.fetch_req;
                  if (bus.fetch_req) begin
                     if (misaligned) begin
                        instr_r <= NOP_WORD;
                        fault_r <= 1'b1;
                        code_r  <= 2'b01;
                     end else if (out_of_range) begin
                        instr_r <= NOP_WORD;
                        fault_r <= 1'b1;
                        code_r  <= 2'b10;
                     end else if (unloaded) begin
                        instr_r <= NOP_WORD;
                        fault_r <= 1'b1;
                        code_r  <= 2'b11;
                     end else begin
                        instr_r <= mem[idx[AW-1:0]];
                        fault_r <= 1'b0;
                        code_r  <= 2'b00;
                     end
                  end
               end
            end
            LOAD: begin
               if (!bus.load_en) begin
                  state <= (bcnt != '0) ? FLUSH : RUN;
               end else if (byte_take) begin
                  if (word_done) begin
                     wptr     <= wptr + LW'(1);
                     bcnt     <= '0;
                     asm_word <= '0;
                  end else begin
                     bcnt     <= bcnt + BCW'(1);
                     asm_word <= asm_next;
                  end
               end
            end
            FLUSH: begin
               wptr     <= wptr + LW'(1);
               bcnt     <= '0;
               asm_word <= '0;
               state    <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.load_ready   = load_ready;
   assign bus.instr        = instr_r;
   assign bus.instr_valid  = valid_r;
   assign bus.fault        = fault_r;
   assign bus.fault_code   = code_r;
   assign bus.loaded_words = wptr;
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Next-generation instruction memory for the RISC-V datapath. It is parametrised in word width and depth and takes a byte-addressed PC. Reads are synchronous with a stall hold, and fetches are checked for misalignment, out-of-range and unloaded addresses. A byte-serial boot-load port fills the array at run time. The block sits between the PC register and the decode stage; the loader is driven by the test harness or a UART bootloader.

Parameters:
DATA_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
DEPTH, 2048, number of words in the array.
ADDR_WIDTH, 32, width of the byte-addressed fetch address.
NOP_WORD, 32'h00000013, word returned on any fault (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
load_en  input  1  level; high requests boot-load mode.
load_valid  input  1  load_byte is valid this cycle.
load_byte  input  8  next program byte, little-endian order.
load_ready  output  1  block accepts a byte this cycle.
fetch_req  input  1  fetch request this cycle.
fetch_addr  input  ADDR_WIDTH  byte address of the instruction.
stall  input  1  downstream stall; hold outputs.
instr  output  DATA_WIDTH  fetched instruction.
instr_valid  output  1  instr and fault are valid.
fault  output  1  fetch fault flag, qualified by instr_valid.
fault_code  output  2  01 misaligned, 10 out of range, 11 unloaded, 00 none.
loaded_words  output  clog2(DEPTH)+1  count of words written since the last load start.

Behaviour:
- Reset (rst_n=0, async):
  - Outputs: state=RUN, instr=0, instr_valid=0, fault=0, fault_code=00, load_ready=0, loaded_words=0.
  - Internal: byte counter=0, write pointer=0.
  - The array contents are not reset. The loaded_words guard makes them unobservable.
- FSM states: RUN, LOAD, FLUSH.
- RUN → LOAD when load_en=1. On entry: write pointer=0, byte counter=0, loaded_words=0, instr_valid=0.
- load_en and fetch_req high in the same RUN cycle: the load wins and the fetch is dropped.
- LOAD:
  - load_ready=1 while write pointer < DEPTH.
  - Each cycle with load_valid && load_ready shifts the byte into the assembly register at byte position = byte counter (little-endian).
  - When byte counter reaches DATA_WIDTH/8-1, the assembled word is written to mem[pointer]; pointer and loaded_words increment and the byte counter wraps to 0.
- Array full (pointer == DEPTH): load_ready=0 and further bytes are ignored.
- LOAD → FLUSH when load_en=0 and byte counter≠0. FLUSH writes the partial word zero-padded in one cycle, increments loaded_words, then goes to RUN.
- LOAD → RUN directly when load_en=0 and byte counter=0.
- Fetches in LOAD or FLUSH are ignored and instr_valid stays 0.
- RUN fetch, latency 1 cycle:
  - If fetch_req=1 and stall=0 at edge N, then after edge N+1: instr_valid=1, and instr/fault/fault_code reflect fetch_addr. Word index = fetch_addr >> log2(DATA_WIDTH/8).
  - Fault priority: misaligned (low byte-offset bits ≠0) → 01; else index ≥ DEPTH → 10; else index ≥ loaded_words → 11; else no fault.
  - On any fault: instr=NOP_WORD, fault=1.
- Stall and idle:
  - stall=1: instr, instr_valid, fault and fault_code hold; fetch_req is not sampled.
  - fetch_req=0 and stall=0: instr_valid=0 next cycle; instr holds its last value.
- Read-during-load is not possible because fetches are blocked outside RUN.
- Reset mid-load: returns to RUN with loaded_words=0, so every fetch faults with code 11 until a new load.

Test Plan:
- Reset, then fetch 0x0 → instr_valid=1, instr=0x00000013, fault=1, fault_code=11 one cycle later.
- Load bytes 03,21,00,01,23,24,01,00; drop load_en → loaded_words=2; fetch 0x0 → 0x01002103; fetch 0x4 → 0x00012423; fault=0.
- Load 5 bytes AA,BB,CC,DD,EE; drop load_en → FLUSH writes 0x000000EE at word 1; loaded_words=2.
- After a valid load, fetch 0x2 → fault_code=01; fetch 4*DEPTH → fault_code=10; both return instr=0x00000013.
- Fetch 0x0 then assert stall for 3 cycles while fetch_addr changes to 0x4 → instr holds 0x01002103 and instr_valid=1 throughout; 0x4 is returned one cycle after stall drops.
- Load DEPTH*4+4 bytes → load_ready=0 after byte DEPTH*4, loaded_words=DEPTH; pulse rst_n low mid-stream → loaded_words=0 and state=RUN.
